// File: rtl/cut_pkg.sv
// Shared definitions for the cutting-blade stepper path: FSM states, direction
// encoding and the half-step coil pattern table.
package cut_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

  // Coil bits are {A, B, A', B'}; consecutive entries differ by one coil.
  function automatic logic [3:0] half_step_coils(input logic [2:0] idx);
    logic [3:0] coils;
    case (idx)
      3'd0:    coils = 4'b1000;
      3'd1:    coils = 4'b1100;
      3'd2:    coils = 4'b0100;
      3'd3:    coils = 4'b0110;
      3'd4:    coils = 4'b0010;
      3'd5:    coils = 4'b0011;
      3'd6:    coils = 4'b0001;
      default: coils = 4'b1001;
    endcase
    return coils;
  endfunction

endpackage

// File: rtl/cut_stepper_driver_if.sv
// Link between cut_controller (master) and the stepper driver (slave).
interface cut_stepper_driver_if #(
  parameter int POS_W = 16
);
  logic                    en_i;
  logic                    direction_i;
  logic [3:0]              coil_o;
  logic                    step_o;
  logic                    busy_o;
  logic signed [POS_W-1:0] position_o;

  modport master (
    output en_i, direction_i,
    input  coil_o, step_o, busy_o, position_o
  );

  modport slave (
    input  en_i, direction_i,
    output coil_o, step_o, busy_o, position_o
  );
endinterface

// File: rtl/cut_step_timer.sv
// Period counter running 0..CYCLES-1 with synchronous clear; o_tc flags the
// last count and the counter wraps to 0 on the following enabled edge.
module cut_step_timer #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int W    = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  // CYCLES = 0 is legal for the hold timer; the top never enters that state then.
  localparam int LAST = (CYCLES > 0) ? CYCLES - 1 : 0;
  localparam logic [W-1:0] LAST_W = W'(LAST);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_tc ? '0 : r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == LAST_W);

endmodule

// File: rtl/cut_stepper_driver.sv
// Half-step sequencer driving the four H-bridge coil lines of the blade stepper,
// with a hold-torque window after stepping stops.
//
// state | meaning
// IDLE  | coils released, idx/position retained
// RUN   | coils energised, stepping every STEP_CYCLES
// HOLD  | coils energised at last pattern for HOLD_CYCLES, no stepping
module cut_stepper_driver
  import cut_pkg::*;
#(
  parameter int STEP_CYCLES = 250000,
  parameter int HOLD_CYCLES = 500000,
  parameter int POS_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cut_stepper_driver_if.slave  bus
);

  localparam bit HOLD_EN = (HOLD_CYCLES > 0);

  state_t           r_state;
  logic [2:0]       r_idx;
  logic [POS_W-1:0] r_position;
  logic [3:0]       r_coil;
  logic             r_step;
  logic             r_busy;

  state_t           w_state_nxt;
  logic [2:0]       w_idx_nxt;
  logic [POS_W-1:0] w_pos_nxt;
  logic [3:0]       w_coil_nxt;
  logic             w_step_nxt;
  logic             w_busy_nxt;
  logic             w_period_clr;
  logic             w_period_tc;
  logic             w_hold_clr;
  logic             w_hold_tc;

  cut_step_timer #(.CYCLES(STEP_CYCLES)) u_period_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_period_clr),
    .i_en  (r_state == ST_RUN),
    .o_tc  (w_period_tc)
  );

  cut_step_timer #(.CYCLES(HOLD_CYCLES)) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_hold_clr),
    .i_en  (r_state == ST_HOLD),
    .o_tc  (w_hold_tc)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_pos_nxt    = r_position;
    w_step_nxt   = 1'b0;
    w_period_clr = 1'b0;
    w_hold_clr   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.en_i) begin
          w_state_nxt  = ST_RUN;
          w_period_clr = 1'b1;
        end
      end
      ST_RUN: begin
        // Dropping en_i suppresses a step even on the terminal count.
        if (!bus.en_i) begin
          if (HOLD_EN) begin
            w_state_nxt = ST_HOLD;
            w_hold_clr  = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_period_tc) begin
          w_step_nxt = 1'b1;
          if (bus.direction_i == DIR_CCW) begin
            w_idx_nxt = r_idx - 3'd1;
            w_pos_nxt = r_position - 1'b1;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
            w_pos_nxt = r_position + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (bus.en_i) begin
          w_state_nxt  = ST_RUN;
          w_period_clr = 1'b1;
        end else if (w_hold_tc) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_coil_nxt = (w_state_nxt == ST_IDLE) ? 4'b0000 : half_step_coils(w_idx_nxt);
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= 3'd0;
      r_position <= '0;
      r_coil     <= 4'b0000;
      r_step     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_position <= w_pos_nxt;
      r_coil     <= w_coil_nxt;
      r_step     <= w_step_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign bus.coil_o     = r_coil;
  assign bus.step_o     = r_step;
  assign bus.busy_o     = r_busy;
  assign bus.position_o = r_position;

endmodule
